// File: rtl/subword_mem_ctrl_if.sv
// Bundle between the EX/MEM stage, the memory-access controller and the DataMemory BRAM port.
// Handshake: a request (MemRead/MemWrite with address and data) is held unchanged by the
// pipeline for every cycle in which MEM_Stall is 1; it completes in the first cycle with MEM_Stall 0.
interface subword_mem_ctrl_if;
   logic [31:0] EX_MEM_Address;
   logic [31:0] EX_MEM_WriteData;
   logic        EX_MEM_MemWrite;
   logic        EX_MEM_MemRead;
   logic        EX_MEM_HalfControl;
   logic        EX_MEM_ByteControl;
   logic        EX_MEM_Unsigned;
   logic [31:0] DM_ReadData;
   logic [31:0] DM_Address;
   logic [31:0] DM_WriteData;
   logic        DM_MemWrite;
   logic [31:0] MEM_LoadData;
   logic        MEM_Stall;
   logic        MEM_Misaligned;

   modport slave (
      input  EX_MEM_Address, EX_MEM_WriteData, EX_MEM_MemWrite, EX_MEM_MemRead,
      input  EX_MEM_HalfControl, EX_MEM_ByteControl, EX_MEM_Unsigned, DM_ReadData,
      output DM_Address, DM_WriteData, DM_MemWrite, MEM_LoadData, MEM_Stall, MEM_Misaligned
   );

   modport master (
      output EX_MEM_Address, EX_MEM_WriteData, EX_MEM_MemWrite, EX_MEM_MemRead,
      output EX_MEM_HalfControl, EX_MEM_ByteControl, EX_MEM_Unsigned, DM_ReadData,
      input  DM_Address, DM_WriteData, DM_MemWrite, MEM_LoadData, MEM_Stall, MEM_Misaligned
   );
endinterface

// File: rtl/subword_mem_ctrl.sv
// Memory-access stage: sub-word stores become a read-modify-write against a word-only BRAM,
// sub-word loads are lane-extracted and sign/zero-extended from the returned word.
module subword_mem_ctrl #(
   parameter int WORD_ADDR_BITS = 10,
   parameter bit LANE_LITTLE    = 1'b1
) (
   input  logic                  Clk,
   input  logic                  Rst_n,
   subword_mem_ctrl_if.slave     bus,
   output logic                  dbg_state_o
);

   typedef enum logic {IDLE = 1'b0, RMW_WRITE = 1'b1} state_t;

   state_t      state_q;
   logic [31:0] merge_q, merge_d;

   logic [31:0] addr;
   logic        in_idle, is_half, is_byte, is_sub;
   logic        misaligned, word_store, sub_store, load_ok;
   logic [4:0]  lane_sh;
   logic [31:0] lane_mask;
   logic [15:0] lane_half;
   logic [7:0]  lane_byte;
   logic [31:0] load_d;

   assign addr = bus.EX_MEM_Address;

   always_comb begin
      in_idle    = (state_q == IDLE);
      is_half    = bus.EX_MEM_HalfControl;
      is_byte    = bus.EX_MEM_ByteControl & ~bus.EX_MEM_HalfControl;
      is_sub     = is_half | is_byte;
      misaligned = in_idle & is_half & addr[0] & (bus.EX_MEM_MemRead | bus.EX_MEM_MemWrite);
      word_store = in_idle & bus.EX_MEM_MemWrite & ~is_sub;
      sub_store  = in_idle & bus.EX_MEM_MemWrite & is_sub & ~misaligned;
      load_ok    = in_idle & bus.EX_MEM_MemRead & ~bus.EX_MEM_MemWrite & ~misaligned;

      // Big-lane builds mirror the offset so offset 0 lands in the top byte/half.
      if (is_half) lane_sh = LANE_LITTLE ? {addr[1], 4'b0000} : {~addr[1], 4'b0000};
      else         lane_sh = LANE_LITTLE ? {addr[1:0], 3'b000} : {~addr[1:0], 3'b000};

      lane_mask = (is_half ? 32'h0000_FFFF : 32'h0000_00FF) << lane_sh;
      merge_d   = (bus.DM_ReadData & ~lane_mask) | ((bus.EX_MEM_WriteData << lane_sh) & lane_mask);
      lane_half = 16'(bus.DM_ReadData >> lane_sh);
      lane_byte = 8'(bus.DM_ReadData >> lane_sh);

      load_d = '0;
      if (load_ok) begin
         if (is_half)      load_d = {{16{~bus.EX_MEM_Unsigned & lane_half[15]}}, lane_half};
         else if (is_byte) load_d = {{24{~bus.EX_MEM_Unsigned & lane_byte[7]}}, lane_byte};
         else              load_d = bus.DM_ReadData;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= IDLE;
         merge_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (sub_store) begin
                  merge_q <= merge_d;
                  state_q <= RMW_WRITE;
               end
            end
            RMW_WRITE: state_q <= IDLE;
            default:   state_q <= IDLE;
         endcase
      end
   end

   assign bus.DM_Address     = {addr[31:WORD_ADDR_BITS+2], addr[WORD_ADDR_BITS+1:2], 2'b00};
   assign bus.DM_WriteData   = in_idle ? bus.EX_MEM_WriteData : merge_q;
   // Gating with Rst_n aborts an in-flight merge write the instant reset asserts.
   assign bus.DM_MemWrite    = Rst_n & (word_store | ~in_idle);
   assign bus.MEM_Stall      = sub_store;
   assign bus.MEM_Misaligned = misaligned;
   assign bus.MEM_LoadData   = load_d;
   assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_subword_mem_ctrl.sv
// Bench: a little-lane and a big-lane controller share one request stream; each has its own
// BRAM model and a byte-array reference memory that defines expected loads and stored words.
module tb_subword_mem_ctrl;

  logic Clk = 1'b0;
  logic Rst_n;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  logic [31:0] ex_addr, ex_wd;
  logic        ex_wr, ex_rd, ex_half, ex_byte, ex_uns;
  logic        dbg_l, dbg_b;

  subword_mem_ctrl_if bus_l();
  subword_mem_ctrl_if bus_b();

  subword_mem_ctrl #(.WORD_ADDR_BITS(10), .LANE_LITTLE(1'b1)) dut_l (
    .Clk(Clk), .Rst_n(Rst_n), .bus(bus_l.slave), .dbg_state_o(dbg_l));
  subword_mem_ctrl #(.WORD_ADDR_BITS(10), .LANE_LITTLE(1'b0)) dut_b (
    .Clk(Clk), .Rst_n(Rst_n), .bus(bus_b.slave), .dbg_state_o(dbg_b));

  assign bus_l.EX_MEM_Address     = ex_addr;
  assign bus_l.EX_MEM_WriteData   = ex_wd;
  assign bus_l.EX_MEM_MemWrite    = ex_wr;
  assign bus_l.EX_MEM_MemRead     = ex_rd;
  assign bus_l.EX_MEM_HalfControl = ex_half;
  assign bus_l.EX_MEM_ByteControl = ex_byte;
  assign bus_l.EX_MEM_Unsigned    = ex_uns;
  assign bus_b.EX_MEM_Address     = ex_addr;
  assign bus_b.EX_MEM_WriteData   = ex_wd;
  assign bus_b.EX_MEM_MemWrite    = ex_wr;
  assign bus_b.EX_MEM_MemRead     = ex_rd;
  assign bus_b.EX_MEM_HalfControl = ex_half;
  assign bus_b.EX_MEM_ByteControl = ex_byte;
  assign bus_b.EX_MEM_Unsigned    = ex_uns;

  // BRAM models: combinational read, write on the falling edge.
  logic [31:0] mem_l [0:1023];
  logic [31:0] mem_b [0:1023];
  logic        bd_req = 1'b0;
  logic [9:0]  bd_idx;
  logic [31:0] bd_l, bd_b;

  assign bus_l.DM_ReadData = mem_l[bus_l.DM_Address[11:2]];
  assign bus_b.DM_ReadData = mem_b[bus_b.DM_Address[11:2]];

  always @(negedge Clk) begin
    if (bd_req) begin
      mem_l[bd_idx] <= bd_l;
      mem_b[bd_idx] <= bd_b;
    end else begin
      if (bus_l.DM_MemWrite) mem_l[bus_l.DM_Address[11:2]] <= bus_l.DM_WriteData;
      if (bus_b.DM_MemWrite) mem_b[bus_b.DM_Address[11:2]] <= bus_b.DM_WriteData;
    end
  end

  // Reference: byte-addressed memories for bytes 0..255, one per lane order.
  logic [7:0] ref_l [0:255];
  logic [7:0] ref_b [0:255];

  function automatic logic [31:0] ref_word(input bit big, input int a);
    if (big) return {ref_b[a], ref_b[a+1], ref_b[a+2], ref_b[a+3]};
    return {ref_l[a+3], ref_l[a+2], ref_l[a+1], ref_l[a]};
  endfunction

  function automatic logic [31:0] ref_load(input bit big, input int a, input int size, input logic uns);
    logic [15:0] h;
    logic [7:0]  b;
    if (size == 4) return ref_word(big, a & ~3);
    if (size == 2) begin
      h = big ? {ref_b[a], ref_b[a+1]} : {ref_l[a+1], ref_l[a]};
      return uns ? {16'h0000, h} : {{16{h[15]}}, h};
    end
    b = big ? ref_b[a] : ref_l[a];
    return uns ? {24'h0, b} : {{24{b[7]}}, b};
  endfunction

  task automatic ref_put(input bit big, input int a, input logic [31:0] wd, input int size);
    if (size == 4) begin
      for (int k = 0; k < 4; k++) begin
        if (big) ref_b[a+k] = wd[31-8*k -: 8];
        else     ref_l[a+k] = wd[8*k +: 8];
      end
    end else if (size == 2) begin
      if (big) begin ref_b[a] = wd[15:8]; ref_b[a+1] = wd[7:0]; end
      else     begin ref_l[a] = wd[7:0];  ref_l[a+1] = wd[15:8]; end
    end else begin
      if (big) ref_b[a] = wd[7:0];
      else     ref_l[a] = wd[7:0];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_req(input logic wr, input logic rd, input logic half, input logic byt,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wd);
    ex_wr = wr; ex_rd = rd; ex_half = half; ex_byte = byt; ex_uns = uns;
    ex_addr = addr; ex_wd = wd;
  endtask

  task automatic idle_req();
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic set_word(input int idx, input logic [31:0] wl, input logic [31:0] wb);
    next_cycle();
    idle_req();
    bd_idx = 10'(idx); bd_l = wl; bd_b = wb; bd_req = 1'b1;
    ref_put(1'b0, idx * 4, wl, 4);
    ref_put(1'b1, idx * 4, wb, 4);
    @(negedge Clk);
    #1 bd_req = 1'b0;
  endtask

  logic [31:0] last_wd_l, last_wd_b;

  task automatic do_store(input logic [31:0] addr, input logic [31:0] wd, input int size,
                          input logic also_rd, input logic both_ctl, input bit abort_rmw);
    int a, wa;
    logic [31:0] old_l, old_b, exp_l, exp_b;
    a = int'(addr[7:0]);
    wa = a & ~3;
    next_cycle();
    set_req(1'b1, also_rd, size == 2, (size == 1) | (size == 2 && both_ctl), 1'b0, addr, wd);
    #3;
    chk("st_addr_l", bus_l.DM_Address, {addr[31:2], 2'b00});
    chk("st_addr_b", bus_b.DM_Address, {addr[31:2], 2'b00});
    chk("st_load_zero_l", bus_l.MEM_LoadData, 32'h0);
    chk("st_load_zero_b", bus_b.MEM_LoadData, 32'h0);
    if (size == 4) begin
      chk("sw_stall", {bus_l.MEM_Stall, bus_b.MEM_Stall}, 32'h0);
      chk("sw_we", {bus_l.DM_MemWrite, bus_b.DM_MemWrite}, 32'h3);
      chk("sw_wd_l", bus_l.DM_WriteData, wd);
      chk("sw_wd_b", bus_b.DM_WriteData, wd);
      ref_put(1'b0, wa, wd, 4);
      ref_put(1'b1, wa, wd, 4);
    end else if (size == 2 && addr[0]) begin
      chk("mis_flag", {bus_l.MEM_Misaligned, bus_b.MEM_Misaligned}, 32'h3);
      chk("mis_we", {bus_l.DM_MemWrite, bus_b.DM_MemWrite}, 32'h0);
      chk("mis_stall", {bus_l.MEM_Stall, bus_b.MEM_Stall}, 32'h0);
    end else begin
      old_l = ref_word(1'b0, wa);
      old_b = ref_word(1'b1, wa);
      ref_put(1'b0, a, wd, size);
      ref_put(1'b1, a, wd, size);
      exp_l = ref_word(1'b0, wa);
      exp_b = ref_word(1'b1, wa);
      chk("rmw_rd_stall", {bus_l.MEM_Stall, bus_b.MEM_Stall}, 32'h3);
      chk("rmw_rd_we", {bus_l.DM_MemWrite, bus_b.DM_MemWrite}, 32'h0);
      chk("rmw_rd_state", {dbg_l, dbg_b}, 32'h0);
      next_cycle();
      #3;
      chk("rmw_wr_stall", {bus_l.MEM_Stall, bus_b.MEM_Stall}, 32'h0);
      chk("rmw_wr_we", {bus_l.DM_MemWrite, bus_b.DM_MemWrite}, 32'h3);
      chk("rmw_wr_state", {dbg_l, dbg_b}, 32'h3);
      chk("rmw_wd_l", bus_l.DM_WriteData, exp_l);
      chk("rmw_wd_b", bus_b.DM_WriteData, exp_b);
      last_wd_l = bus_l.DM_WriteData;
      last_wd_b = bus_b.DM_WriteData;
      if (abort_rmw) begin
        Rst_n = 1'b0;
        #1;
        chk("abort_we", {bus_l.DM_MemWrite, bus_b.DM_MemWrite}, 32'h0);
        chk("abort_state", {dbg_l, dbg_b}, 32'h0);
        idle_req();
        ref_put(1'b0, wa, old_l, 4);
        ref_put(1'b1, wa, old_b, 4);
        @(negedge Clk);
        #3 Rst_n = 1'b1;
      end
    end
  endtask

  task automatic do_load(input logic [31:0] addr, input int size, input logic uns,
                         input logic both_ctl, output logic [31:0] obs_l);
    int a;
    a = int'(addr[7:0]);
    next_cycle();
    set_req(1'b0, 1'b1, size == 2, (size == 1) | (size == 2 && both_ctl), uns, addr, 32'h0);
    #3;
    chk("ld_addr", bus_l.DM_Address, {addr[31:2], 2'b00});
    chk("ld_we", {bus_l.DM_MemWrite, bus_b.DM_MemWrite}, 32'h0);
    chk("ld_stall", {bus_l.MEM_Stall, bus_b.MEM_Stall}, 32'h0);
    if (size == 2 && addr[0]) begin
      chk("ld_mis_flag", {bus_l.MEM_Misaligned, bus_b.MEM_Misaligned}, 32'h3);
      chk("ld_mis_data_l", bus_l.MEM_LoadData, 32'h0);
      chk("ld_mis_data_b", bus_b.MEM_LoadData, 32'h0);
    end else begin
      chk("ld_mis_flag", {bus_l.MEM_Misaligned, bus_b.MEM_Misaligned}, 32'h0);
      exp_q.push_back(ref_load(1'b0, a, size, uns));
      exp_q.push_back(ref_load(1'b1, a, size, uns));
      chk("ld_data_l", bus_l.MEM_LoadData, exp_q.pop_front());
      chk("ld_data_b", bus_b.MEM_LoadData, exp_q.pop_front());
    end
    obs_l = bus_l.MEM_LoadData;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] obs, r, addr, wd;
    int kind, size;

    // Reset behaviour
    Rst_n = 1'b0;
    idle_req();
    #2;
    chk("rst_state", {dbg_l, dbg_b}, 32'h0);
    chk("rst_stall", {bus_l.MEM_Stall, bus_b.MEM_Stall}, 32'h0);
    chk("rst_mis", {bus_l.MEM_Misaligned, bus_b.MEM_Misaligned}, 32'h0);
    chk("rst_load", bus_l.MEM_LoadData, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h1234_5678);
    #1;
    chk("rst_we_forced", {bus_l.DM_MemWrite, bus_b.DM_MemWrite}, 32'h0);
    idle_req();
    #10 Rst_n = 1'b1;

    for (int i = 0; i < 64; i++) begin
      r = $urandom;
      set_word(i, r, r);
    end

    // Word store then word load
    do_store(32'h0000_0010, 32'hDEAD_BEEF, 4, 1'b0, 1'b0, 1'b0);
    do_load(32'h0000_0010, 4, 1'b0, 1'b0, obs);
    chk("lw_deadbeef", obs, 32'hDEAD_BEEF);

    // Byte store read-modify-write and byte loads
    set_word(4, 32'h1122_3344, 32'h1122_3344);
    do_store(32'h0000_0012, 32'h0000_00AA, 1, 1'b0, 1'b0, 1'b0);
    chk("sb_merge_l", last_wd_l, 32'h11AA_3344);
    do_load(32'h0000_0012, 1, 1'b0, 1'b0, obs);
    chk("lb_sext", obs, 32'hFFFF_FFAA);
    do_load(32'h0000_0012, 1, 1'b1, 1'b0, obs);
    chk("lbu_zext", obs, 32'h0000_00AA);

    // Back-to-back halfword stores into one word
    do_store(32'h0000_0010, 32'h0000_8001, 2, 1'b0, 1'b0, 1'b0);
    do_store(32'h0000_0012, 32'h0000_7FFF, 2, 1'b0, 1'b1, 1'b0);
    chk("sh_pair_word_l", last_wd_l, 32'h7FFF_8001);
    do_load(32'h0000_0010, 2, 1'b0, 1'b0, obs);
    chk("lh_sext", obs, 32'hFFFF_8001);
    do_load(32'h0000_0012, 2, 1'b1, 1'b0, obs);
    chk("lhu_zext", obs, 32'h0000_7FFF);

    // Misaligned halfword store leaves memory alone
    do_store(32'h0000_0011, 32'h0000_BEEF, 2, 1'b0, 1'b0, 1'b0);
    next_cycle();
    idle_req();
    chk("mis_mem_l", mem_l[4], 32'h7FFF_8001);

    // Reset during the merge write aborts it
    set_word(8, 32'h5555_5555, 32'h5555_5555);
    do_store(32'h0000_0020, 32'h0000_00AB, 1, 1'b0, 1'b0, 1'b1);
    next_cycle();
    chk("abort_mem_l", mem_l[8], 32'h5555_5555);
    chk("abort_mem_b", mem_b[8], 32'h5555_5555);
    chk("abort_idle", {dbg_l, dbg_b}, 32'h0);

    // Big-lane mirror: offset 0 is the top byte
    set_word(4, 32'h1122_3344, 32'h1122_3344);
    do_store(32'h0000_0010, 32'h0000_00CC, 1, 1'b0, 1'b0, 1'b0);
    chk("sb_big_merge", last_wd_b, 32'hCC22_3344);
    chk("sb_little_merge", last_wd_l, 32'h1122_33CC);

    // Random traffic over bytes 0..255 with random upper address bits
    for (int n = 0; n < 300; n++) begin
      r = $urandom;
      addr = {r[31:12], 4'h0, 8'($urandom_range(0, 255))};
      wd = $urandom;
      kind = $urandom_range(0, 1);
      case ($urandom_range(0, 2))
        0: size = 1;
        1: size = 2;
        default: size = 4;
      endcase
      if (kind == 0) do_store(addr, wd, size, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      else           do_load(addr, size, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), obs);
    end
    next_cycle();
    idle_req();
    next_cycle();

    for (int i = 0; i < 64; i++) begin
      chk("final_mem_l", mem_l[i], ref_word(1'b0, i * 4));
      chk("final_mem_b", mem_b[i], ref_word(1'b1, i * 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
